uart_tx_fifo: RTL

Parametrised UART transmitter with an integrated transmit FIFO, configurable data width, optional parity and 1 or 2 stop bits. Host pushes words with a valid strobe. The block drains the FIFO and serialises each word LSB-first on txd, one bit per bclk strobe. Frames go out back-to-back with no idle gap while data is queued.

---
 rtl/uart_tx_fifo.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a first-word-fall-through FIFO; LSB-first, optional parity, 1/2 stop bits.
// Define TX_CTS_EN to add the active-low cts_n input that gates the start of each frame.
module uart_tx_fifo #(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 16,
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bclk,
    input  logic [DATA_W-1:0] din,
    input  logic              tx_en,
    input  logic              par_en,
    input  logic              par_odd,
    input  logic              stop2,
`ifdef TX_CTS_EN
    input  logic              cts_n,
`endif
    output logic              full,
    output logic [CNT_W-1:0]  level,
    output logic              ovf,
    output logic              txd,
    output logic              tx_rdy
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int BIT_W  = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              empty;
    logic              push;
    logic              pop;
    logic              start_ok;
    logic [DATA_W-1:0] head;

    state_t            state;
    logic [DATA_W-1:0] shift;
    logic [BIT_W-1:0]  bit_cnt;
    logic              stop_cnt;
    logic              par_acc;
    logic              par_next;
    logic              cfg_par;
    logic              cfg_stop2;

    assign full  = (level == CNT_W'(FIFO_DEPTH));
    assign empty = (level == '0);
    assign push  = tx_en && !full;
    assign head  = mem[rd_ptr];

`ifdef TX_CTS_EN
    assign start_ok = !empty && !cts_n;
`else
    assign start_ok = !empty;
`endif

    // A frame may begin from IDLE, or from STOP once the last stop bit has been sent.
    assign pop = bclk && start_ok &&
                 ((state == IDLE) || ((state == STOP) && !(cfg_stop2 && !stop_cnt)));

    assign par_next = par_acc ^ shift[0];
    assign tx_rdy   = (state == IDLE) && empty;

    // NOTE: the storage array has no reset; only pointers and level define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            ovf <= tx_en && full;
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   level <= level + CNT_W'(1);
                2'b01:   level <= level - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            txd       <= 1'b1;
            shift     <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            par_acc   <= 1'b0;
            cfg_par   <= 1'b0;
            cfg_stop2 <= 1'b0;
        end else if (bclk) begin
            if (pop) begin
                shift     <= head;
                cfg_par   <= par_en;
                cfg_stop2 <= stop2;
                par_acc   <= par_odd;
                txd       <= 1'b0;
                state     <= START;
            end else begin
                unique case (state)
                    IDLE: begin
                        txd <= 1'b1;
                    end
                    START: begin
                        txd     <= shift[0];
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                    DATA: begin
                        par_acc <= par_next;
                        if (bit_cnt == LAST_BIT) begin
                            if (cfg_par) begin
                                txd   <= par_next;
                                state <= PARITY;
                            end else begin
                                txd      <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            shift   <= shift >> 1;
                            txd     <= shift[1];
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                    PARITY: begin
                        txd      <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                    STOP: begin
                        txd <= 1'b1;
                        if (cfg_stop2 && !stop_cnt) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        txd   <= 1'b1;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
